// File: rtl/clkdiv_prog.sv
// Runtime-programmable integer clock divider with period-boundary ratio handshake and calib phase slip.
// Optional programmable high time via `define CLKDIV_PROG_DUTY_EN (adds duty_hi input).
module clkdiv_prog #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DIV_DEFAULT = 4
) (
  input  logic             hclkin,
  input  logic             reset,
  input  logic [CNT_W-1:0] div_val,
`ifdef CLKDIV_PROG_DUTY_EN
  input  logic [CNT_W-1:0] duty_hi,
`endif
  input  logic             div_load,
  output logic             div_ack,
  output logic             cfg_err,
  input  logic             calib,
  output logic             clkout,
  output logic             ce_rise,
  output logic             ce_fall,
  output logic             locked,
  output logic [CNT_W-1:0] div_cur
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clkout_q, clkout_d;
  logic             ce_rise_q, ce_rise_d;
  logic             ce_fall_q, ce_fall_d;
  logic             div_ack_q, div_ack_d;
  logic             cfg_err_q, cfg_err_d;
  logic             locked_q, locked_d;
  logic             clean_q, clean_d;
  logic             calib_q;

  logic             active, slip, wrap, load_ok, load_bad, apply;
  logic [CNT_W:0]   hi;

`ifdef CLKDIV_PROG_DUTY_EN
  localparam logic [CNT_W-1:0] HI_RST = CNT_W'((DIV_DEFAULT + 1) / 2);
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] pend_hi_q, pend_hi_d;
  logic [CNT_W-1:0] duty_clamped;
  logic             duty_bad;

  always_comb begin
    duty_clamped = duty_hi;
    duty_bad     = 1'b0;
    if (duty_hi == '0) begin
      duty_clamped = ONE;
      duty_bad     = 1'b1;
    end else if (duty_hi >= div_val) begin
      duty_clamped = div_val - ONE;
      duty_bad     = 1'b1;
    end
  end

  assign hi = {1'b0, hi_q};
`else
  assign hi = ({1'b0, div_cur_q} + (CNT_W+1)'(1)) >> 1;
`endif

  assign active   = (state_q == RUN) || (state_q == PEND);
  assign slip     = active && calib && !calib_q;
  assign wrap     = active && !slip && (cnt_q == div_cur_q - ONE);
  assign load_ok  = (state_q == RUN) && div_load && (div_val >= TWO);
  assign load_bad = (state_q == RUN) && div_load && (div_val < TWO);
  // A load accepted on the wrap cycle applies at that same wrap.
  assign apply    = wrap && ((state_q == PEND) || load_ok);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    pend_d    = pend_q;
    clkout_d  = clkout_q;
    ce_rise_d = 1'b0;
    ce_fall_d = 1'b0;
    div_ack_d = 1'b0;
    cfg_err_d = 1'b0;
    locked_d  = locked_q;
    clean_d   = clean_q;
`ifdef CLKDIV_PROG_DUTY_EN
    hi_d      = hi_q;
    pend_hi_d = pend_hi_q;
`endif

    if (state_q == IDLE) begin
      state_d = RUN;
    end else if (!slip) begin
      cnt_d     = wrap ? '0 : cnt_q + ONE;
      clkout_d  = ({1'b0, cnt_q} < hi);
      ce_rise_d = clkout_d && !clkout_q;
      ce_fall_d = !clkout_d && clkout_q;
    end

    if (load_ok) begin
      pend_d  = div_val;
      state_d = PEND;
`ifdef CLKDIV_PROG_DUTY_EN
      pend_hi_d = duty_clamped;
      cfg_err_d = duty_bad;
`endif
    end
    if (load_bad) cfg_err_d = 1'b1;

    if (apply) begin
      div_cur_d = (state_q == PEND) ? pend_q : div_val;
      div_ack_d = 1'b1;
      state_d   = RUN;
`ifdef CLKDIV_PROG_DUTY_EN
      hi_d = (state_q == PEND) ? pend_hi_q : duty_clamped;
`endif
    end

    if (slip || apply) locked_d = 1'b0;
    else if (wrap && clean_q) locked_d = 1'b1;

    if (slip) clean_d = 1'b0;
    else if (wrap) clean_d = 1'b1;
  end

  always_ff @(posedge hclkin) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_cur_q <= DIV_RST;
      pend_q    <= '0;
      clkout_q  <= 1'b0;
      ce_rise_q <= 1'b0;
      ce_fall_q <= 1'b0;
      div_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
      locked_q  <= 1'b0;
      clean_q   <= 1'b1;
      calib_q   <= 1'b0;
`ifdef CLKDIV_PROG_DUTY_EN
      hi_q      <= HI_RST;
      pend_hi_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      clkout_q  <= clkout_d;
      ce_rise_q <= ce_rise_d;
      ce_fall_q <= ce_fall_d;
      div_ack_q <= div_ack_d;
      cfg_err_q <= cfg_err_d;
      locked_q  <= locked_d;
      clean_q   <= clean_d;
      calib_q   <= calib;
`ifdef CLKDIV_PROG_DUTY_EN
      hi_q      <= hi_d;
      pend_hi_q <= pend_hi_d;
`endif
    end
  end

  assign clkout  = clkout_q;
  assign ce_rise = ce_rise_q;
  assign ce_fall = ce_fall_q;
  assign div_ack = div_ack_q;
  assign cfg_err = cfg_err_q;
  assign locked  = locked_q;
  assign div_cur = div_cur_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed self-checking bench for clkdiv_prog (default build, DIV_DEFAULT=4).
module tb_clkdiv_prog;

  logic       hclkin = 1'b0;
  logic       reset;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_ack;
  logic       cfg_err;
  logic       calib;
  logic       clkout;
  logic       ce_rise;
  logic       ce_fall;
  logic       locked;
  logic [7:0] div_cur;
`ifdef CLKDIV_PROG_DUTY_EN
  logic [7:0] duty_hi = 8'd0;
`endif

  int checks = 0;
  int errors = 0;

  clkdiv_prog #(.CNT_W(8), .DIV_DEFAULT(4)) dut (
    .hclkin   (hclkin),
    .reset    (reset),
    .div_val  (div_val),
`ifdef CLKDIV_PROG_DUTY_EN
    .duty_hi  (duty_hi),
`endif
    .div_load (div_load),
    .div_ack  (div_ack),
    .cfg_err  (cfg_err),
    .calib    (calib),
    .clkout   (clkout),
    .ce_rise  (ce_rise),
    .ce_fall  (ce_fall),
    .locked   (locked),
    .div_cur  (div_cur)
  );

  always #5 hclkin = ~hclkin;

  task automatic tick();
    @(posedge hclkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Step n cycles; bit vectors list expected values first-cycle-first (MSB side).
  task automatic seq(input string tag, input int n, input logic [15:0] ec, input logic [15:0] er,
                     input logic [15:0] ef, input logic [15:0] el, input logic [15:0] ea);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s[%0d].clkout", tag, i), {31'd0, clkout}, {31'd0, ec[n-1-i]});
      chk($sformatf("%s[%0d].ce_rise", tag, i), {31'd0, ce_rise}, {31'd0, er[n-1-i]});
      chk($sformatf("%s[%0d].ce_fall", tag, i), {31'd0, ce_fall}, {31'd0, ef[n-1-i]});
      chk($sformatf("%s[%0d].locked", tag, i), {31'd0, locked}, {31'd0, el[n-1-i]});
      chk($sformatf("%s[%0d].div_ack", tag, i), {31'd0, div_ack}, {31'd0, ea[n-1-i]});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".clkout"},  {31'd0, clkout},  32'd0);
    chk({tag, ".ce_rise"}, {31'd0, ce_rise}, 32'd0);
    chk({tag, ".ce_fall"}, {31'd0, ce_fall}, 32'd0);
    chk({tag, ".div_ack"}, {31'd0, div_ack}, 32'd0);
    chk({tag, ".cfg_err"}, {31'd0, cfg_err}, 32'd0);
    chk({tag, ".locked"},  {31'd0, locked},  32'd0);
    chk({tag, ".div_cur"}, {24'd0, div_cur}, 32'd4);
  endtask

  initial begin
    reset = 1'b1; div_val = 8'd0; div_load = 1'b0; calib = 1'b0;
    tick(); tick();
    chk_reset("rst");

    // Default divide-by-4 from reset release
    reset = 1'b0;
    seq("idle", 1, 16'b0, 16'b0, 16'b0, 16'b0, 16'b0);
    seq("n4", 8, 16'b11001100, 16'b10001000, 16'b00100010, 16'b00011111, 16'b0);

    // Load 5 at cnt=0: old period completes, then ack
    div_load = 1'b1; div_val = 8'd5;
    seq("ld5a", 1, 16'b1, 16'b1, 16'b0, 16'b1, 16'b0);
    div_load = 1'b0;
    seq("ld5b", 2, 16'b10, 16'b00, 16'b01, 16'b11, 16'b00);
    chk("ld5.div_cur_old", {24'd0, div_cur}, 32'd4);
    seq("n5", 7, 16'b0111001, 16'b0100001, 16'b0000100, 16'b0000011, 16'b1000000);
    chk("n5.div_cur", {24'd0, div_cur}, 32'd5);

    // Invalid ratio, then valid load of 4, then ignored load of 6 in PEND
    div_load = 1'b1; div_val = 8'd1;
    tick();
    chk("bad.cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("bad.div_ack", {31'd0, div_ack}, 32'd0);
    chk("bad.div_cur", {24'd0, div_cur}, 32'd5);
    div_val = 8'd4;
    tick();
    chk("ld4.cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("ld4.div_ack", {31'd0, div_ack}, 32'd0);
    div_val = 8'd6;
    tick();
    chk("ld6.cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("ld6.div_ack", {31'd0, div_ack}, 32'd0);
    chk("ld6.div_cur", {24'd0, div_cur}, 32'd5);
    div_load = 1'b0;
    tick();
    chk("ap4.div_ack", {31'd0, div_ack}, 32'd1);
    chk("ap4.div_cur", {24'd0, div_cur}, 32'd4);
    chk("ap4.cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("ap4.locked",  {31'd0, locked},  32'd0);
    seq("n4b", 4, 16'b1100, 16'b1000, 16'b0010, 16'b0001, 16'b0);
    chk("n4b.div_cur", {24'd0, div_cur}, 32'd4);

    // Calib slip right after a wrap stretches the low phase
    calib = 1'b1;
    seq("slip", 1, 16'b0, 16'b0, 16'b0, 16'b0, 16'b0);
    seq("slipa", 2, 16'b11, 16'b10, 16'b00, 16'b00, 16'b00);
    calib = 1'b0;
    seq("slipb", 7, 16'b0011001, 16'b0010001, 16'b1000100, 16'b0000011, 16'b0);

    // Load on the wrap cycle together with a calib edge
    seq("prew", 2, 16'b10, 16'b00, 16'b01, 16'b11, 16'b00);
    div_load = 1'b1; div_val = 8'd5; calib = 1'b1;
    seq("wslip", 1, 16'b0, 16'b0, 16'b0, 16'b0, 16'b0);
    div_load = 1'b0; calib = 1'b0;
    seq("wapply", 6, 16'b011100, 16'b010000, 16'b000010, 16'b000001, 16'b100000);
    chk("wapply.div_cur", {24'd0, div_cur}, 32'd5);

    // Reset while in PEND discards the pending ratio
    div_load = 1'b1; div_val = 8'd7;
    tick();
    chk("pend7.div_ack", {31'd0, div_ack}, 32'd0);
    div_load = 1'b0; reset = 1'b1;
    tick();
    chk_reset("rst2");
    tick();
    reset = 1'b0; calib = 1'b1;
    seq("post", 6, 16'b011001, 16'b010001, 16'b000100, 16'b000011, 16'b0);
    chk("post.div_cur", {24'd0, div_cur}, 32'd4);
    seq("post2", 5, 16'b10011, 16'b00010, 16'b01000, 16'b11111, 16'b0);
    chk("post2.div_cur", {24'd0, div_cur}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
